// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory arbiter.
// Optional statistics counters in the top level are enabled by DMEM_ARB_STATS_EN.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam int unsigned WORD_BYTES = 8;

  // A full 8-byte word must fit below DEPTH.
  function automatic logic in_range(input logic [63:0] addr, input int unsigned depth);
    return (addr <= 64'(depth - WORD_BYTES));
  endfunction

  function automatic logic [1:0] port_vec(input logic port);
    return port ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin picker; remembers the last-served port.
// Reset leaves port 1 as last served, so port 0 wins the first tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req_i,
  input  logic       upd_i,
  input  logic       upd_port_i,
  output logic       pick_o,
  output logic       valid_o
);

  logic last_q;

  // Last-served pointer, updated once per granted access.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q <= 1'b1;
    end else if (upd_i) begin
      last_q <= upd_port_i;
    end else begin
      last_q <= last_q;
    end
  end

  // Pick the only requester, or on a tie the one not served last.
  always_comb begin
    valid_o = |req_i;
    pick_o  = 1'b0;
    if (req_i == 2'b11) begin
      pick_o = ~last_q;
    end else if (req_i[1]) begin
      pick_o = 1'b1;
    end else begin
      pick_o = 1'b0;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter and IDLE->ACCESS->RESP sequencer in front of the data memory.
// Defining DMEM_ARB_STATS_EN adds saturating per-port and error counters.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = 64
`ifdef DMEM_ARB_STATS_EN
  , parameter int unsigned CNT_W = 16
`endif
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [63:0] p0_addr,
  input  logic [63:0] p0_wdata,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [63:0] p1_addr,
  input  logic [63:0] p1_wdata,
  output logic        p0_gnt,
  output logic        p0_done,
  output logic [63:0] p0_rdata,
  output logic        p0_err,
  output logic        p1_gnt,
  output logic        p1_done,
  output logic [63:0] p1_rdata,
  output logic        p1_err,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic        mem_write,
  output logic        mem_read,
  input  logic [63:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
  , output logic [CNT_W-1:0] p0_count
  , output logic [CNT_W-1:0] p1_count
  , output logic [CNT_W-1:0] err_count
`endif
);

  state_e      state_q;
  logic        sel_q;
  logic        we_q;
  logic        ok_q;
  logic [1:0]  gnt_q;
  logic [1:0]  done_q;
  logic [1:0]  err_q;
  logic [1:0]  rd_q;
  logic [63:0] mem_addr_q;
  logic [63:0] mem_wdata_q;
  logic        mem_write_q;
  logic        mem_read_q;

  logic        pick_s;
  logic        valid_s;
  logic        sel_we_s;
  logic        sel_ok_s;
  logic [63:0] sel_addr_s;
  logic [63:0] sel_wdata_s;

  rr_arb2 u_arb (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_i      ({p1_req, p0_req}),
    .upd_i      (state_q == ACCESS),
    .upd_port_i (sel_q),
    .pick_o     (pick_s),
    .valid_o    (valid_s)
  );

  // Mux the winning port's request fields and range-check its address.
  always_comb begin
    sel_we_s    = 1'b0;
    sel_addr_s  = 64'd0;
    sel_wdata_s = 64'd0;
    if (pick_s) begin
      sel_we_s    = p1_we;
      sel_addr_s  = p1_addr;
      sel_wdata_s = p1_wdata;
    end else begin
      sel_we_s    = p0_we;
      sel_addr_s  = p0_addr;
      sel_wdata_s = p0_wdata;
    end
    sel_ok_s = in_range(sel_addr_s, DEPTH);
  end

  // Sequencer; every output is registered so it is valid in the state it belongs to.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      sel_q       <= 1'b0;
      we_q        <= 1'b0;
      ok_q        <= 1'b0;
      gnt_q       <= 2'b00;
      done_q      <= 2'b00;
      err_q       <= 2'b00;
      rd_q        <= 2'b00;
      mem_addr_q  <= 64'd0;
      mem_wdata_q <= 64'd0;
      mem_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
    end else begin
      gnt_q       <= 2'b00;
      done_q      <= 2'b00;
      err_q       <= 2'b00;
      rd_q        <= 2'b00;
      mem_addr_q  <= 64'd0;
      mem_wdata_q <= 64'd0;
      mem_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (valid_s) begin
            state_q <= ACCESS;
            sel_q   <= pick_s;
            we_q    <= sel_we_s;
            ok_q    <= sel_ok_s;
            gnt_q   <= port_vec(pick_s);
            // Out-of-range accesses never reach the memory.
            if (sel_ok_s) begin
              mem_addr_q  <= sel_addr_s;
              mem_wdata_q <= sel_wdata_s;
              mem_write_q <= sel_we_s;
              mem_read_q  <= ~sel_we_s;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        ACCESS: begin
          state_q <= RESP;
          done_q  <= port_vec(sel_q);
          err_q   <= ok_q ? 2'b00 : port_vec(sel_q);
          rd_q    <= (ok_q && !we_q) ? port_vec(sel_q) : 2'b00;
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign p0_gnt    = gnt_q[0];
  assign p1_gnt    = gnt_q[1];
  assign p0_done   = done_q[0];
  assign p1_done   = done_q[1];
  assign p0_err    = err_q[0];
  assign p1_err    = err_q[1];
  // Memory data arrives in RESP, so it is gated by a registered per-port enable.
  assign p0_rdata  = rd_q[0] ? mem_rdata : 64'd0;
  assign p1_rdata  = rd_q[1] ? mem_rdata : 64'd0;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_write = mem_write_q;
  assign mem_read  = mem_read_q;

`ifdef DMEM_ARB_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] p0_cnt_q;
  logic [CNT_W-1:0] p1_cnt_q;
  logic [CNT_W-1:0] err_cnt_q;

  // Saturating counters, stepped on the edge that raises done.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p0_cnt_q  <= {CNT_W{1'b0}};
      p1_cnt_q  <= {CNT_W{1'b0}};
      err_cnt_q <= {CNT_W{1'b0}};
    end else if (state_q == ACCESS) begin
      if (!sel_q && p0_cnt_q != CNT_MAX) p0_cnt_q <= p0_cnt_q + CNT_ONE;
      if (sel_q && p1_cnt_q != CNT_MAX) p1_cnt_q <= p1_cnt_q + CNT_ONE;
      if (!ok_q && err_cnt_q != CNT_MAX) err_cnt_q <= err_cnt_q + CNT_ONE;
    end else begin
      p0_cnt_q  <= p0_cnt_q;
      p1_cnt_q  <= p1_cnt_q;
      err_cnt_q <= err_cnt_q;
    end
  end

  assign p0_count  = p0_cnt_q;
  assign p1_count  = p1_cnt_q;
  assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized self-checking bench for dmem_arbiter against a transaction-level model.
// Builds with or without DMEM_ARB_STATS_EN.
module tb_dmem_arbiter;

  localparam int DEPTH = 64;
`ifdef DMEM_ARB_STATS_EN
  localparam int CNT_W = 2;
  logic [CNT_W-1:0] p0_count, p1_count, err_count;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        p0_req, p1_req, p0_we, p1_we;
  logic [63:0] p0_addr, p1_addr, p0_wdata, p1_wdata;
  logic        p0_gnt, p1_gnt, p0_done, p1_done, p0_err, p1_err;
  logic [63:0] p0_rdata, p1_rdata;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_write, mem_read;

  logic [1:0]  pend;
  logic        rq_we    [2];
  logic [63:0] rq_addr  [2];
  logic [63:0] rq_wdata [2];

  logic [7:0]  sram    [DEPTH];
  logic [7:0]  ref_mem [DEPTH];
  int          last_srv;
  int          cnt [2];
  int          cnt_err;
  int          n_tests = 0;
  int          n_fail  = 0;
  logic        prev_strobe = 1'b0;

  assign p0_req   = pend[0];
  assign p1_req   = pend[1];
  assign p0_we    = rq_we[0];
  assign p1_we    = rq_we[1];
  assign p0_addr  = rq_addr[0];
  assign p1_addr  = rq_addr[1];
  assign p0_wdata = rq_wdata[0];
  assign p1_wdata = rq_wdata[1];

  always #5 clk = ~clk;

  dmem_arbiter #(
    .DEPTH(DEPTH)
`ifdef DMEM_ARB_STATS_EN
    , .CNT_W(CNT_W)
`endif
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p0_gnt(p0_gnt), .p0_done(p0_done), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_gnt(p1_gnt), .p1_done(p1_done), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
    .mem_read(mem_read), .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_STATS_EN
    , .p0_count(p0_count), .p1_count(p1_count), .err_count(err_count)
`endif
  );

  // Behavioural byte memory with one-cycle read latency.
  always @(posedge clk) begin
    if (mem_read)
      for (int b = 0; b < 8; b++) mem_rdata[8*b +: 8] <= sram[(int'(mem_addr[5:0]) + b) % DEPTH];
    if (mem_write)
      for (int b = 0; b < 8; b++) sram[(int'(mem_addr[5:0]) + b) % DEPTH] <= mem_wdata[8*b +: 8];
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Strobes must be exclusive single-cycle pulses.
  always @(negedge clk) begin
    if (mem_read || mem_write) begin
      check_eq("strobe_excl", 64'(mem_read & mem_write), 64'd0);
      check_eq("strobe_width", 64'(prev_strobe), 64'd0);
    end
    prev_strobe = mem_read | mem_write;
  end

  function automatic logic [63:0] ref_word(input logic [63:0] a);
    logic [63:0] w;
    for (int b = 0; b < 8; b++) w[8*b +: 8] = ref_mem[int'(a[5:0]) + b];
    return w;
  endfunction

  task automatic set_req(input int p, input logic we, input logic [63:0] a, input logic [63:0] wd);
    pend[p]     = 1'b1;
    rq_we[p]    = we;
    rq_addr[p]  = a;
    rq_wdata[p] = wd;
  endtask

  task automatic rand_req(input int p);
    logic [63:0] a;
    case ($urandom_range(0, 7))
      0:       a = {$urandom, $urandom};
      1:       a = 64'($urandom_range(57, 63));
      default: a = 64'($urandom_range(0, 56));
    endcase
    set_req(p, 1'($urandom_range(0, 1)), a, {$urandom, $urandom});
  endtask

  // One complete transaction: called in an IDLE cycle with at least one request pending.
  task automatic serve_one(input bit hold, output logic [63:0] got, output int won);
    int          waited;
    bit          ok, we;
    logic [63:0] a, exp_rd;
    got = 64'd0;
    won = (pend == 2'b11) ? ((last_srv == 0) ? 1 : 0) : (pend[1] ? 1 : 0);
    we  = rq_we[won];
    a   = rq_addr[won];
    ok  = (a <= 64'(DEPTH - 8));
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!(p0_gnt || p1_gnt) && waited < 8);
    check_eq("gnt_latency", 64'(waited), 64'd1);
    if (!(p0_gnt || p1_gnt)) return;
    check_eq("gnt_vec", {62'd0, p1_gnt, p0_gnt}, 64'd1 << won);
    check_eq("mem_read", 64'(mem_read), 64'(ok && !we));
    check_eq("mem_write", 64'(mem_write), 64'(ok && we));
    if (ok) check_eq("mem_addr", mem_addr, a);
    if (ok && we) check_eq("mem_wdata", mem_wdata, rq_wdata[won]);
    exp_rd = (ok && !we) ? ref_word(a) : 64'd0;
    if (ok && we)
      for (int b = 0; b < 8; b++) ref_mem[int'(a[5:0]) + b] = rq_wdata[won][8*b +: 8];
    last_srv = won;
    cnt[won]++;
    if (!ok) cnt_err++;
    if (!hold) pend[won] = 1'b0;
    @(negedge clk);
    check_eq("gnt_pulse", {62'd0, p1_gnt, p0_gnt}, 64'd0);
    check_eq("done_vec", {62'd0, p1_done, p0_done}, 64'd1 << won);
    check_eq("err_vec", {62'd0, p1_err, p0_err}, ok ? 64'd0 : (64'd1 << won));
    got = (won == 1) ? p1_rdata : p0_rdata;
    check_eq("rdata", got, exp_rd);
    check_eq("rdata_other", (won == 1) ? p0_rdata : p1_rdata, 64'd0);
    @(negedge clk);
    check_eq("done_pulse", {62'd0, p1_done, p0_done}, 64'd0);
    check_eq("strobe_idle", {62'd0, mem_read, mem_write}, 64'd0);
  endtask

  initial begin
    logic [63:0] got;
    int          won;
    reset_n  = 1'b0;
    pend     = 2'b00;
    for (int p = 0; p < 2; p++) begin
      rq_we[p] = 1'b0; rq_addr[p] = 64'd0; rq_wdata[p] = 64'd0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      sram[i]    = 8'(14 + (i % 2));
      ref_mem[i] = 8'(14 + (i % 2));
    end
    last_srv = 1; cnt[0] = 0; cnt[1] = 0; cnt_err = 0;
    repeat (3) @(negedge clk);
    check_eq("rst_ctrl", {56'd0, p0_gnt, p1_gnt, p0_done, p1_done, p0_err, p1_err, mem_read, mem_write}, 64'd0);
    check_eq("rst_rdata", p0_rdata | p1_rdata, 64'd0);
    check_eq("rst_mem_addr", mem_addr, 64'd0);
    reset_n = 1'b1;

    set_req(0, 1'b0, 64'd0, 64'd0);
    serve_one(1'b0, got, won);
    check_eq("p0_load0", got, 64'h0F0E0F0E0F0E0F0E);

    set_req(1, 1'b1, 64'd8, 64'h1122334455667788);
    serve_one(1'b0, got, won);
    set_req(1, 1'b0, 64'd8, 64'd0);
    serve_one(1'b0, got, won);
    check_eq("p1_load8", got, 64'h1122334455667788);

    set_req(0, 1'b0, 64'd16, 64'd0);
    set_req(1, 1'b0, 64'd24, 64'd0);
    for (int i = 0; i < 4; i++) begin
      serve_one(1'b1, got, won);
      check_eq("tie_order", 64'(won), 64'(i % 2));
    end
    pend = 2'b00;

    set_req(0, 1'b0, 64'd57, 64'd0);
    serve_one(1'b0, got, won);
    check_eq("oor_rdata", got, 64'd0);

    for (int r = 0; r < 80; r++) begin
      for (int p = 0; p < 2; p++) if (!pend[p] && $urandom_range(0, 1) == 1) rand_req(p);
      if (pend == 2'b00) rand_req(int'($urandom_range(0, 1)));
      serve_one(1'b0, got, won);
    end
    pend = 2'b00;

    set_req(0, 1'b0, 64'd16, 64'd0);
    @(negedge clk);
    check_eq("pre_rst_gnt", {62'd0, p0_gnt, mem_read}, 64'd3);
    #2 reset_n = 1'b0;
    #1 check_eq("async_drop", {60'd0, p0_gnt, p1_gnt, mem_read, mem_write}, 64'd0);
    pend = 2'b00;
    repeat (2) begin
      @(negedge clk);
      check_eq("no_done_rst", {62'd0, p1_done, p0_done}, 64'd0);
    end
    reset_n = 1'b1;
    last_srv = 1; cnt[0] = 0; cnt[1] = 0; cnt_err = 0;

    set_req(0, 1'b0, 64'd0, 64'd0);
    set_req(1, 1'b0, 64'd24, 64'd0);
    serve_one(1'b0, got, won);
    check_eq("post_rst_tie", 64'(won), 64'd0);
    pend = 2'b00;
    for (int i = 0; i < 4; i++) begin
      set_req(0, 1'b0, (i == 2) ? 64'hFFFF_FFFF_FFFF_FFF8 : 64'(8 * i), 64'd0);
      serve_one(1'b0, got, won);
    end
`ifdef DMEM_ARB_STATS_EN
    check_eq("p0_count", 64'(p0_count), 64'((cnt[0] > 3) ? 3 : cnt[0]));
    check_eq("p1_count", 64'(p1_count), 64'((cnt[1] > 3) ? 3 : cnt[1]));
    check_eq("err_count", 64'(err_count), 64'((cnt_err > 3) ? 3 : cnt_err));
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
